// File: rtl/pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pe_sequencer
// Description : Job sequencer for a PE array. It loads the weights once, then
//               for each row loads activations, streams, shifts and writes the
//               result row back to the global buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_sequencer #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] OUT_BASE = 10'd512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        num_rows,
    input  logic              done_GB,
    output logic [2:0]        state,
    output logic [3:0]        write_w_to_PE_ctr,
    output logic [3:0]        write_a_to_PE_ctr,
    output logic              gb_rd,
    output logic              gb_wr,
    output logic [ADDR_W-1:0] gb_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_INIT   = 3'd1;
    localparam logic [2:0] c_ST_DONE   = 3'd2;
    localparam logic [2:0] c_ST_LOAD_W = 3'd3;
    localparam logic [2:0] c_ST_LOAD_A = 3'd4;
    localparam logic [2:0] c_ST_STREAM = 3'd5;
    localparam logic [2:0] c_ST_SHIFT  = 3'd6;
    localparam logic [2:0] c_ST_WB     = 3'd7;

    localparam logic [3:0]        c_LOAD_LAST  = 4'd8;
    localparam logic [2:0]        c_STREAM_MAX = 3'd7;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [3:0]        r_w_ctr;
    logic [3:0]        r_a_ctr;
    logic [ADDR_W-1:0] r_gb_addr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [3:0]        r_row_ctr;
    logic [3:0]        r_rows;
    logic [2:0]        r_stream_cnt;
    logic              r_flag;

    logic [3:0]        w_row_next;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W-1:0] w_wb_addr;
    logic              w_w_reading;
    logic              w_a_reading;
    logic              w_stream_exit;

    assign w_row_next    = r_row_ctr + 4'd1;
    assign w_addr_inc    = r_gb_addr + c_ADDR_ONE;
    assign w_wb_addr     = OUT_BASE + {{(ADDR_W-4){1'b0}}, r_row_ctr};
    assign w_w_reading   = (r_w_ctr < c_LOAD_LAST);
    assign w_a_reading   = (r_a_ctr < c_LOAD_LAST);
    assign w_stream_exit = (r_stream_cnt == c_STREAM_MAX) && (done_GB || r_flag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_w_ctr      <= 4'd0;
            r_a_ctr      <= 4'd0;
            r_gb_addr    <= '0;
            r_rd_ptr     <= '0;
            r_row_ctr    <= 4'd0;
            r_rows       <= 4'd1;
            r_stream_cnt <= 3'd0;
            r_flag       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_INIT;
                    end
                end
                c_ST_INIT: begin
                    r_rows       <= (num_rows == 4'd0) ? 4'd1 : num_rows;
                    r_row_ctr    <= 4'd0;
                    r_w_ctr      <= 4'd0;
                    r_a_ctr      <= 4'd0;
                    r_gb_addr    <= '0;
                    r_rd_ptr     <= '0;
                    r_stream_cnt <= 3'd0;
                    r_flag       <= 1'b0;
                    r_state      <= c_ST_LOAD_W;
                end
                c_ST_LOAD_W: begin
                    if (w_w_reading) begin
                        r_w_ctr   <= r_w_ctr + 4'd1;
                        r_gb_addr <= w_addr_inc;
                        r_rd_ptr  <= w_addr_inc;
                    end else begin
                        r_a_ctr <= 4'd0;
                        r_state <= c_ST_LOAD_A;
                    end
                end
                c_ST_LOAD_A: begin
                    if (w_a_reading) begin
                        r_a_ctr   <= r_a_ctr + 4'd1;
                        r_gb_addr <= w_addr_inc;
                        r_rd_ptr  <= w_addr_inc;
                    end else begin
                        r_state <= c_ST_STREAM;
                    end
                end
                c_ST_STREAM: begin
                    // The flag keeps an early completion alive until the
                    // minimum dwell has elapsed.
                    if (w_stream_exit) begin
                        r_state <= c_ST_SHIFT;
                    end else begin
                        if (done_GB) begin
                            r_flag <= 1'b1;
                        end
                        if (r_stream_cnt != c_STREAM_MAX) begin
                            r_stream_cnt <= r_stream_cnt + 3'd1;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    r_stream_cnt <= 3'd0;
                    r_flag       <= 1'b0;
                    r_gb_addr    <= w_wb_addr;
                    r_state      <= c_ST_WB;
                end
                c_ST_WB: begin
                    if (done_GB) begin
                        r_row_ctr <= w_row_next;
                        r_gb_addr <= r_rd_ptr;
                        if (w_row_next == r_rows) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_a_ctr <= 4'd0;
                            r_state <= c_ST_LOAD_A;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_w_ctr <= 4'd0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign state             = r_state;
    assign write_w_to_PE_ctr = r_w_ctr;
    assign write_a_to_PE_ctr = r_a_ctr;
    assign gb_addr           = r_gb_addr;
    assign gb_rd             = ((r_state == c_ST_LOAD_W) && w_w_reading) ||
                               ((r_state == c_ST_LOAD_A) && w_a_reading) ||
                               (r_state == c_ST_STREAM);
    assign gb_wr             = (r_state == c_ST_WB);
    assign busy              = (r_state != c_ST_IDLE);
    assign done              = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_sequencer
// Description : Self-checking bench for pe_sequencer; expected cycle traces
//               are generated per job from the phase rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_INIT = 3'd1, ST_DONE = 3'd2, ST_LW = 3'd3;
    localparam logic [2:0] ST_LA   = 3'd4, ST_STR  = 3'd5, ST_SH   = 3'd6, ST_WB = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] num_rows;
    logic       done_GB;
    logic [2:0] state;
    logic [3:0] write_w_to_PE_ctr;
    logic [3:0] write_a_to_PE_ctr;
    logic       gb_rd;
    logic       gb_wr;
    logic [9:0] gb_addr;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    pe_sequencer #(.ADDR_W(10), .OUT_BASE(10'd512)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .done_GB(done_GB),
        .state(state), .write_w_to_PE_ctr(write_w_to_PE_ctr), .write_a_to_PE_ctr(write_a_to_PE_ctr),
        .gb_rd(gb_rd), .gb_wr(gb_wr), .gb_addr(gb_addr), .busy(busy), .done(done)
    );

    // One expected cycle: outputs to see, and inputs to drive during that cycle.
    typedef struct {
        logic [2:0] st;
        logic       rd;
        logic       wr;
        logic       dn;
        logic [9:0] addr;
        bit         ca;
        logic [3:0] wc;
        logic [3:0] ac;
        bit         cc;
        logic       s_in;
        logic       dgb;
        logic       rstn;
    } rec_t;

    rec_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input logic [2:0] st, input logic [9:0] addr, input bit ca,
                        input logic [3:0] wc, input logic [3:0] ac, input bit cc,
                        input logic s_in, input logic dgb, input logic rstn);
        rec_t r;
        r.st   = st;
        r.rd   = (st == ST_LW && wc < 8) || (st == ST_LA && ac < 8) || (st == ST_STR);
        r.wr   = (st == ST_WB);
        r.dn   = (st == ST_DONE);
        r.addr = addr;
        r.ca   = ca;
        r.wc   = wc;
        r.ac   = ac;
        r.cc   = cc;
        r.s_in = s_in;
        r.dgb  = dgb;
        r.rstn = rstn;
        q.push_back(r);
    endtask

    // smode: 0 random completion timing, 1 completion on 8th stream cycle,
    // 2 single early completion on 2nd stream cycle.
    task automatic build_job(input int rows_in, input bit hold, input bit stray,
                             input int abort_row, input int smode, input int wb_len);
        int rows, p, dwell, pulse, wl, sa;
        rows = (rows_in == 0) ? 1 : rows_in;
        p    = 0;
        push(ST_IDLE, 10'd0, 0, 4'd0, 4'd0, 0, 1'b1, 1'b0, 1'b1);
        push(ST_INIT, 10'd0, 0, 4'd0, 4'd0, 0, hold, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            push(ST_LW, p[9:0], i < 8, 4'(i), 4'd0, 1, hold, 1'b0, 1'b1);
            if (i < 8) p++;
        end
        for (int r = 0; r < rows; r++) begin
            sa = stray ? int'($urandom_range(0, 8)) : -1;
            for (int i = 0; i < 9; i++) begin
                push(ST_LA, p[9:0], i < 8, 4'd8, 4'(i), 1, hold, i == sa, 1'b1);
                if (i < 8) p++;
            end
            case (smode)
                1: begin dwell = 8; pulse = 8; end
                2: begin dwell = 8; pulse = 2; end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        dwell = 8;
                        pulse = $urandom_range(1, 8);
                    end else begin
                        dwell = $urandom_range(8, 11);
                        pulse = dwell;
                    end
                end
            endcase
            for (int k = 1; k <= dwell; k++) begin
                if (r == abort_row && k == 3) begin
                    push(ST_STR, 10'd0, 0, 4'd8, 4'd8, 1, hold, 1'b0, 1'b0);
                    push(ST_IDLE, 10'd0, 1, 4'd0, 4'd0, 1, 1'b0, 1'b0, 1'b1);
                    return;
                end
                push(ST_STR, 10'd0, 0, 4'd8, 4'd8, 1, hold, k == pulse, 1'b1);
            end
            push(ST_SH, 10'd0, 0, 4'd8, 4'd8, 1, hold, 1'b0, 1'b1);
            wl = (wb_len > 0) ? wb_len : int'($urandom_range(1, 4));
            for (int k = 1; k <= wl; k++)
                push(ST_WB, 10'(512 + r), 1, 4'd8, 4'd8, 1, hold, k == wl, 1'b1);
        end
        push(ST_DONE, 10'd0, 0, 4'd8, 4'd8, 1, hold, 1'b0, 1'b1);
        push(ST_IDLE, 10'd0, 0, 4'd0, 4'd8, 1, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [24:0] exp_of(input rec_t r);
        return {r.st, r.rd, r.wr, r.st != ST_IDLE, r.dn, r.addr, r.wc, r.ac};
    endfunction

    function automatic logic [24:0] mask_of(input rec_t r);
        return {7'h7f, {10{r.ca}}, {8{r.cc}}};
    endfunction

    // Sample the current cycle, drive its inputs, advance to the next cycle.
    task automatic step(input rec_t r, output logic [24:0] got);
        got     = {state, gb_rd, gb_wr, busy, done, gb_addr, write_w_to_PE_ctr, write_a_to_PE_ctr};
        start   = r.s_in;
        done_GB = r.dgb;
        rst_n   = r.rstn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; done_GB = 1'b1; num_rows = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
        vectors++; if ({gb_rd, gb_wr, busy, done} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got=%b exp=0000", {gb_rd, gb_wr, busy, done}); end
        vectors++; if (gb_addr !== 10'd0) begin miscompares++; $display("FAIL reset_addr got=%0d exp=0", gb_addr); end
        vectors++; if ({write_w_to_PE_ctr, write_a_to_PE_ctr} !== 8'd0) begin miscompares++; $display("FAIL reset_ctrs got=%h exp=00", {write_w_to_PE_ctr, write_a_to_PE_ctr}); end
        start = 1'b0; done_GB = 1'b0; rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (state !== 3'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_release got st=%0d busy=%b exp st=0 busy=0", state, busy); end
    endtask

    task automatic test_nominal;
        rec_t e; logic [24:0] got, m; int n, nrd, nwb, ndn; logic [2:0] prev;
        n = 0; nrd = 0; nwb = 0; ndn = 0; prev = ST_IDLE;
        num_rows = 4'd1;
        build_job(1, 0, 0, -1, 1, 3);
        while (q.size() > 0) begin
            e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
            if ((got & m) !== (exp_of(e) & m)) begin
                miscompares++;
                $display("FAIL nominal cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", n, got[24:22], got & m, e.st, exp_of(e) & m);
            end
            if (got[21] && (got[24:22] == ST_LW || got[24:22] == ST_LA)) begin
                vectors++;
                if (got[17:8] !== 10'(nrd)) begin miscompares++; $display("FAIL nominal_rd_addr got=%0d exp=%0d", got[17:8], nrd); end
                nrd++;
            end
            if (got[24:22] == ST_WB && prev != ST_WB) begin
                nwb++;
                vectors++;
                if (got[17:8] !== 10'd512) begin miscompares++; $display("FAIL nominal_wr_addr got=%0d exp=512", got[17:8]); end
            end
            if (got[18]) ndn++;
            prev = got[24:22]; n++;
        end
        vectors++; if (nrd != 16) begin miscompares++; $display("FAIL nominal_reads got=%0d exp=16", nrd); end
        vectors++; if (nwb != 1) begin miscompares++; $display("FAIL nominal_writes got=%0d exp=1", nwb); end
        vectors++; if (ndn != 1) begin miscompares++; $display("FAIL nominal_done_cycles got=%0d exp=1", ndn); end
    endtask

    task automatic test_three_rows;
        rec_t e; logic [24:0] got, m; int n, nlw, nla, nwb, maxa; logic [2:0] prev;
        n = 0; nlw = 0; nla = 0; nwb = 0; maxa = 0; prev = ST_IDLE;
        num_rows = 4'd3;
        build_job(3, 0, 0, -1, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
            if ((got & m) !== (exp_of(e) & m)) begin
                miscompares++;
                $display("FAIL three_rows cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", n, got[24:22], got & m, e.st, exp_of(e) & m);
            end
            if (got[24:22] == ST_LW && prev != ST_LW) nlw++;
            if (got[24:22] == ST_LA && prev != ST_LA) nla++;
            if (got[24:22] == ST_WB && prev != ST_WB) nwb++;
            if (got[21] && got[24:22] != ST_STR && int'(got[17:8]) > maxa) maxa = int'(got[17:8]);
            prev = got[24:22]; n++;
        end
        vectors++; if (nlw != 1) begin miscompares++; $display("FAIL three_rows_loadw got=%0d exp=1", nlw); end
        vectors++; if (nla != 3) begin miscompares++; $display("FAIL three_rows_loada got=%0d exp=3", nla); end
        vectors++; if (nwb != 3) begin miscompares++; $display("FAIL three_rows_writes got=%0d exp=3", nwb); end
        vectors++; if (maxa != 31) begin miscompares++; $display("FAIL three_rows_max_rd got=%0d exp=31", maxa); end
    endtask

    task automatic test_early_done;
        rec_t e; logic [24:0] got, m; int n, nstr;
        n = 0; nstr = 0;
        num_rows = 4'd1;
        build_job(1, 0, 0, -1, 2, 0);
        while (q.size() > 0) begin
            e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
            if ((got & m) !== (exp_of(e) & m)) begin
                miscompares++;
                $display("FAIL early_done cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", n, got[24:22], got & m, e.st, exp_of(e) & m);
            end
            if (got[24:22] == ST_STR) nstr++;
            n++;
        end
        vectors++; if (nstr != 8) begin miscompares++; $display("FAIL early_done_dwell got=%0d exp=8", nstr); end
    endtask

    task automatic test_zero_rows;
        rec_t e; logic [24:0] got, m; int n, nwb; logic [2:0] prev;
        n = 0; nwb = 0; prev = ST_IDLE;
        num_rows = 4'd0;
        build_job(0, 0, 0, -1, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
            if ((got & m) !== (exp_of(e) & m)) begin
                miscompares++;
                $display("FAIL zero_rows cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", n, got[24:22], got & m, e.st, exp_of(e) & m);
            end
            if (got[24:22] == ST_WB && prev != ST_WB) nwb++;
            prev = got[24:22]; n++;
        end
        vectors++; if (nwb != 1) begin miscompares++; $display("FAIL zero_rows_writes got=%0d exp=1", nwb); end
    endtask

    task automatic test_reset_mid_job;
        rec_t e; logic [24:0] got, m; int n, ndn, nwb; logic [2:0] prev;
        n = 0; ndn = 0; nwb = 0; prev = ST_IDLE;
        num_rows = 4'd3;
        build_job(3, 0, 0, 1, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
            if ((got & m) !== (exp_of(e) & m)) begin
                miscompares++;
                $display("FAIL abort cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", n, got[24:22], got & m, e.st, exp_of(e) & m);
            end
            if (got[18]) ndn++;
            n++;
        end
        vectors++; if (ndn != 0) begin miscompares++; $display("FAIL abort_done_pulse got=%0d exp=0", ndn); end
        build_job(3, 0, 0, -1, 0, 0);
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
            if ((got & m) !== (exp_of(e) & m)) begin
                miscompares++;
                $display("FAIL after_abort cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", n, got[24:22], got & m, e.st, exp_of(e) & m);
            end
            if (got[24:22] == ST_WB && prev != ST_WB) nwb++;
            prev = got[24:22]; n++;
        end
        vectors++; if (nwb != 3) begin miscompares++; $display("FAIL after_abort_writes got=%0d exp=3", nwb); end
    endtask

    task automatic test_start_held;
        rec_t e; logic [24:0] got, m; int n, ninit; logic [2:0] prev;
        n = 0; ninit = 0; prev = ST_IDLE;
        num_rows = 4'd2;
        build_job(2, 1, 1, -1, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
            if ((got & m) !== (exp_of(e) & m)) begin
                miscompares++;
                $display("FAIL start_held cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", n, got[24:22], got & m, e.st, exp_of(e) & m);
            end
            if (got[24:22] == ST_INIT && prev != ST_INIT) ninit++;
            prev = got[24:22]; n++;
        end
        vectors++; if (ninit != 1) begin miscompares++; $display("FAIL start_held_inits got=%0d exp=1", ninit); end
    endtask

    task automatic test_random_jobs;
        rec_t e; logic [24:0] got, m; int n, rows;
        for (int j = 0; j < 5; j++) begin
            rows     = $urandom_range(0, 5);
            num_rows = 4'(rows);
            build_job(rows, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1, 0, 0);
            n = 0;
            while (q.size() > 0) begin
                e = q.pop_front(); step(e, got); m = mask_of(e); vectors++;
                if ((got & m) !== (exp_of(e) & m)) begin
                    miscompares++;
                    $display("FAIL random job %0d cyc %0d: got st=%0d vec=%h exp st=%0d vec=%h", j, n, got[24:22], got & m, e.st, exp_of(e) & m);
                end
                n++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; done_GB = 1'b0; num_rows = 4'd1;
        test_reset();
        test_nominal();
        test_three_rows();
        test_early_done();
        test_zero_rows();
        test_reset_mid_job();
        test_start_held();
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameter: ADDR_W, 10, global-buffer (GB) address width.
REQ-002 Parameter: OUT_BASE, 10'd512, GB base address for write-back rows.
REQ-003 Port: clk  input  1  single clock; all logic on posedge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  job start request; honoured only in IDLE.
REQ-006 Port: num_rows  input  4  rows per job; sampled in INIT; 0 treated as 1.
REQ-007 Port: done_GB  input  1  one-cycle GB read/write completion pulse.
REQ-008 Port: state  output  3  PE phase code: 0 IDLE, 1 INIT, 2 DONE, 3 LOAD_W, 4 LOAD_A, 5 STREAM, 6 SHIFT, 7 WRITEBACK.
REQ-009 Port: write_w_to_PE_ctr  output  4  weight write counter, 0..8.
REQ-010 Port: write_a_to_PE_ctr  output  4  activation write counter, 0..8.
REQ-011 Port: gb_rd  output  1  GB read enable.
REQ-012 Port: gb_wr  output  1  GB write enable.
REQ-013 Port: gb_addr  output  ADDR_W  GB address.
REQ-014 Port: busy  output  1  high whenever state != IDLE.
REQ-015 Port: done  output  1  one-cycle job-complete pulse.

Function
REQ-016 state, all counters and gb_addr shall be registered; gb_rd, gb_wr, busy and done shall be decoded combinationally from the registered values.
REQ-017 IDLE: start=1 -> INIT on the next edge; start=0 -> stay in IDLE.
REQ-018 INIT, one cycle: latch num_rows (0 -> 1), clear row_ctr, both PE counters and gb_addr; then go to LOAD_W.
REQ-019 LOAD_W: write_w_to_PE_ctr increments each cycle from 0 to 8 and then holds; gb_rd=1 and gb_addr increments while the counter is < 8; when the counter = 8, go to LOAD_A and clear write_a_to_PE_ctr (9 cycles in LOAD_W).
REQ-020 LOAD_A: same rules as LOAD_W applied to write_a_to_PE_ctr; when the counter = 8, go to STREAM.
REQ-021 STREAM: gb_rd=1; internal stream_cnt counts 0..7 and saturates at 7; a done_GB pulse sets a sticky flag.
REQ-022 STREAM exits to SHIFT when stream_cnt = 7 and (done_GB or flag); minimum STREAM dwell is 8 cycles; an early done_GB is never lost.
REQ-023 SHIFT: exactly one cycle, then WRITEBACK; stream_cnt and the flag are cleared.
REQ-024 WRITEBACK: gb_wr=1, gb_addr = OUT_BASE + row_ctr; held until done_GB.
REQ-025 On done_GB in WRITEBACK, row_ctr increments; if the new row_ctr = latched num_rows, go to DONE; otherwise go to LOAD_A with write_a_to_PE_ctr = 0. Weights are not reloaded.
REQ-026 gb_addr for activation reads resumes from its last read value after write-back; reads are never re-issued.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; write_w_to_PE_ctr is cleared.
REQ-028 done_GB outside STREAM and WRITEBACK shall be ignored.
REQ-029 start while busy shall be ignored and never latched.
REQ-030 gb_rd and gb_wr shall never be high in the same cycle.

Reset
REQ-031 When rst_n=0 at a posedge, on that edge: state=0, both PE counters=0, gb_addr=0, row_ctr=0, stream_cnt=0, flag=0.
REQ-032 As a consequence of REQ-031, gb_rd, gb_wr, busy and done are 0 in the cycle following a reset edge.
REQ-033 Reset mid-job aborts the job with no done pulse; the next start begins a fresh job from INIT.

Verification
REQ-034 Nominal, 1 row: num_rows=1, start pulse, done_GB at STREAM cycle 8 and at WRITEBACK cycle 3 -> state sequence 0,1,3x9,4x9,5x8,6,7x3,2,0; 16 reads at addr 0..15, then 1 write at addr 512; done high 1 cycle.
REQ-035 Three rows: num_rows=3 -> LOAD_W entered once, LOAD_A entered 3 times; writes at 512, 513, 514; read addresses reach 31.
REQ-036 Early done_GB: pulse at STREAM cycle 2 and none later -> SHIFT entered after the 8th STREAM cycle.
REQ-037 num_rows=0 -> behaves identically to num_rows=1; exactly 1 write-back.
REQ-038 Reset asserted during STREAM of row 2 of 3 -> next cycle state=0, all outputs 0, no done pulse; a new start runs a full job correctly.
REQ-039 start held high through an entire job, plus a stray done_GB in LOAD_A -> no re-entry into INIT until after DONE; counters unaffected by the stray pulse.
